// File: rtl/miriscv_lsu.sv
// Load-store unit: turns a core access into a single word-aligned RAM
// request, stalls the core for one cycle and returns the extended load data.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_fault_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic {
    IDLE,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5
  } size_t;

  state_t      state;
  logic        size_ok;
  logic        misaligned;
  logic        fault;
  logic        accept;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata_ext;
  logic [31:0] rshift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign rshift   = data_rdata_i >> {lsu_addr_i[1:0], 3'b000};
  assign byte_sel = rshift[7:0];
  assign half_sel = lsu_addr_i[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

  // Size decode: legality, alignment, byte enables, store replication, load extension
  always_comb begin
    size_ok    = 1'b1;
    misaligned = 1'b0;
    be         = '0;
    wdata      = lsu_data_i;
    rdata_ext  = data_rdata_i;
    case (lsu_size_i)
      SZ_B: begin
        be        = 4'b0001 << lsu_addr_i[1:0];
        wdata     = {4{lsu_data_i[7:0]}};
        rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_BU: begin
        be        = 4'b0001 << lsu_addr_i[1:0];
        wdata     = {4{lsu_data_i[7:0]}};
        rdata_ext = {24'h0, byte_sel};
      end
      SZ_H: begin
        misaligned = lsu_addr_i[0];
        be         = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{lsu_data_i[15:0]}};
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
      end
      SZ_HU: begin
        misaligned = lsu_addr_i[0];
        be         = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{lsu_data_i[15:0]}};
        rdata_ext  = {16'h0, half_sel};
      end
      SZ_W: begin
        misaligned = |lsu_addr_i[1:0];
        be         = 4'b1111;
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign fault = !size_ok || misaligned;

  // Reset is folded in so stall and RAM request drop the instant reset asserts,
  // even while the core keeps lsu_req_i high.
  assign accept = rst_n_i && (state == IDLE) && lsu_req_i;

  assign lsu_stall_req_o = accept;
  assign data_req_o      = accept && !fault;
  assign data_we_o       = data_req_o && lsu_we_i;
  assign data_be_o       = data_req_o ? be : '0;
  assign data_addr_o     = {lsu_addr_i[31:2], 2'b00};
  assign data_wdata_o    = wdata;

  // Two-state access FSM with registered load result and fault pulse
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      lsu_data_o  <= '0;
      lsu_fault_o <= 1'b0;
    end else begin
      lsu_fault_o <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_req_i) begin
            state <= DONE;
            if (fault) begin
              lsu_fault_o <= 1'b1;
            end else if (!lsu_we_i) begin
              lsu_data_o <= rdata_ext;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Bench for miriscv_lsu: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a byte-level memory model.
module tb_miriscv_lsu;

  logic        clk;
  logic        rst_n;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        stall;
  logic [31:0] lsu_data;
  logic        lsu_fault;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;

  miriscv_lsu dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .lsu_req_i       (lsu_req),
    .lsu_we_i        (lsu_we),
    .lsu_size_i      (lsu_size),
    .lsu_addr_i      (lsu_addr),
    .lsu_data_i      (lsu_wdata),
    .lsu_stall_req_o (stall),
    .lsu_data_o      (lsu_data),
    .lsu_fault_o     (lsu_fault),
    .data_req_o      (data_req),
    .data_we_o       (data_we),
    .data_be_o       (data_be),
    .data_addr_o     (data_addr),
    .data_wdata_o    (data_wdata),
    .data_rdata_i    (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: combinational read, byte-enabled write at the clock edge
  logic [31:0] ram [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  assign data_rdata = ram[data_addr[7:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_idx] <= pre_val;
    end else if (rst_n && data_req && data_we) begin
      for (int i = 0; i < 4; i++)
        if (data_be[i]) ram[data_addr[7:2]][8*i +: 8] <= data_wdata[8*i +: 8];
    end
  end

  // Reference model state: memory as plain bytes plus the expected load register
  logic [7:0]  refm [256];
  logic [31:0] exp_data;
  int          n_cmp;
  int          n_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {refm[4*idx+3], refm[4*idx+2], refm[4*idx+1], refm[4*idx]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [7:0] a);
    int     nb = size_bytes(sz);
    longint v  = 0;
    for (int i = 0; i < nb; i++) v += longint'(refm[int'(a) + i]) << (8 * i);
    if (!sz[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v -= (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic preset(input int idx, input logic [31:0] w);
    pre_we  = 1'b1;
    pre_idx = idx[5:0];
    pre_val = w;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
    for (int i = 0; i < 4; i++) refm[4*idx+i] = w[8*i +: 8];
  endtask

  // One full access, called at posedge+1 with the DUT in IDLE
  task automatic do_access(input string nm, input logic we, input logic [2:0] sz,
                           input logic [23:0] hi, input logic [7:0] a, input logic [31:0] d,
                           output logic [3:0] got_be, output logic [31:0] got_ld,
                           output logic got_fault);
    int          nb  = size_bytes(sz);
    logic        flt = (nb == 0) || ((int'(a) % nb) != 0);
    logic [3:0]  ebe = '0;
    logic [31:0] ewd;
    if (!flt) for (int i = 0; i < nb; i++) ebe[int'(a) % 4 + i] = 1'b1;
    ewd = (nb == 1) ? d[7:0] * 32'h01010101 : (nb == 2) ? d[15:0] * 32'h00010001 : d;
    lsu_req   = 1'b1;
    lsu_we    = we;
    lsu_size  = sz;
    lsu_addr  = {hi, a};
    lsu_wdata = d;
    @(negedge clk);
    check({nm, "_stall1"}, 32'(stall), 32'(1));
    check({nm, "_req"}, 32'(data_req), 32'(!flt));
    check({nm, "_we"}, 32'(data_we), 32'(!flt && we));
    check({nm, "_be"}, 32'(data_be), 32'(ebe));
    check({nm, "_addr"}, data_addr, {hi, a[7:2], 2'b00});
    if (we && !flt) check({nm, "_wdata"}, data_wdata, ewd);
    got_be = data_be;
    @(posedge clk);
    if (!flt) begin
      if (we) for (int i = 0; i < nb; i++) refm[int'(a) + i] = d[8*i +: 8];
      else    exp_data = model_load(sz, a);
    end
    #1;
    check({nm, "_stall0"}, 32'(stall), 32'(0));
    check({nm, "_req_done"}, 32'(data_req), 32'(0));
    check({nm, "_ld"}, lsu_data, exp_data);
    check({nm, "_fault"}, 32'(lsu_fault), 32'(flt));
    check({nm, "_mem"}, ram[a[7:2]], ref_word(int'(a[7:2])));
    got_ld    = lsu_data;
    got_fault = lsu_fault;
    lsu_req   = 1'b0;
    @(posedge clk);
    #1;
    check({nm, "_fault_clr"}, 32'(lsu_fault), 32'(0));
  endtask

  typedef struct {
    string       nm;
    logic        we;
    logic [2:0]  sz;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        flt;
    logic [31:0] ld;
  } vec_t;

  vec_t        tbl[$];
  logic [3:0]  g_be;
  logic [31:0] g_ld;
  logic        g_flt;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    exp_data  = '0;
    pre_we    = 1'b0;
    pre_idx   = '0;
    pre_val   = '0;
    rst_n     = 1'b0;
    lsu_req   = 1'b0;
    lsu_we    = 1'b0;
    lsu_size  = 3'd0;
    lsu_addr  = '0;
    lsu_wdata = '0;

    tbl.push_back('{"sw_10",  1'b1, 3'd2, 8'h10, 32'hDEADBEEF, 4'hF,    1'b0, 32'h0});
    tbl.push_back('{"lw_10",  1'b0, 3'd2, 8'h10, 32'h0,        4'hF,    1'b0, 32'hDEADBEEF});
    tbl.push_back('{"lb_23",  1'b0, 3'd0, 8'h23, 32'h0,        4'b1000, 1'b0, 32'hFFFFFF80});
    tbl.push_back('{"lbu_23", 1'b0, 3'd4, 8'h23, 32'h0,        4'b1000, 1'b0, 32'h00000080});
    tbl.push_back('{"lb_21",  1'b0, 3'd0, 8'h21, 32'h0,        4'b0010, 1'b0, 32'h0000007F});
    tbl.push_back('{"sh_32",  1'b1, 3'd1, 8'h32, 32'h00008001, 4'b1100, 1'b0, 32'h0000007F});
    tbl.push_back('{"lh_32",  1'b0, 3'd1, 8'h32, 32'h0,        4'b1100, 1'b0, 32'hFFFF8001});
    tbl.push_back('{"lhu_32", 1'b0, 3'd5, 8'h32, 32'h0,        4'b1100, 1'b0, 32'h00008001});
    tbl.push_back('{"lw_12",  1'b0, 3'd2, 8'h12, 32'h0,        4'h0,    1'b1, 32'h00008001});
    tbl.push_back('{"lh_13",  1'b0, 3'd1, 8'h13, 32'h0,        4'h0,    1'b1, 32'h00008001});
    tbl.push_back('{"sw_12",  1'b1, 3'd2, 8'h12, 32'h11223344, 4'h0,    1'b1, 32'h00008001});
    tbl.push_back('{"sz3_10", 1'b1, 3'd3, 8'h10, 32'h55667788, 4'h0,    1'b1, 32'h00008001});

    // Memory image loaded during reset; a held request must not leak through reset
    for (int i = 0; i < 64; i++) preset(i, $urandom);
    lsu_req = 1'b1;
    #1;
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_req", 32'(data_req), 32'(0));
    check("rst_data", lsu_data, 32'h0);
    check("rst_fault", 32'(lsu_fault), 32'(0));
    lsu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Halfword store touches only the upper half of the word at 0x30
    preset(12, 32'hCAFE5A5A);
    do_access("sh1234", 1'b1, 3'd1, 24'h0, 8'h32, 32'hABCD1234, g_be, g_ld, g_flt);
    check("sh1234_word", ram[12], 32'h12345A5A);
    preset(8, 32'h80FF7F01);

    foreach (tbl[k]) begin
      do_access(tbl[k].nm, tbl[k].we, tbl[k].sz, 24'h0, tbl[k].a, tbl[k].d, g_be, g_ld, g_flt);
      check({tbl[k].nm, "_tbe"}, 32'(g_be), 32'(tbl[k].be));
      check({tbl[k].nm, "_tflt"}, 32'(g_flt), 32'(tbl[k].flt));
      check({tbl[k].nm, "_tld"}, g_ld, tbl[k].ld);
    end
    check("fault_mem_10", ram[4], 32'hDEADBEEF);

    // Request held high across four cycles: accepted only every other cycle
    lsu_req  = 1'b1;
    lsu_we   = 1'b0;
    lsu_size = 3'd2;
    lsu_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_stall", 32'(stall), 32'(i % 2 == 0));
      check("b2b_req", 32'(data_req), 32'(i % 2 == 0));
      @(posedge clk);
    end
    #1;
    exp_data = model_load(3'd2, 8'h10);
    check("b2b_ld", lsu_data, exp_data);

    // Async reset while in DONE, request kept high throughout
    @(negedge clk);
    @(posedge clk);
    #1;
    check("ar_done_stall", 32'(stall), 32'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_stall", 32'(stall), 32'(0));
    check("ar_req", 32'(data_req), 32'(0));
    check("ar_data", lsu_data, 32'h0);
    check("ar_fault", 32'(lsu_fault), 32'(0));
    exp_data = '0;
    #2;
    rst_n = 1'b1;
    #1;
    check("ar_idle_stall", 32'(stall), 32'(1));
    check("ar_idle_req", 32'(data_req), 32'(1));
    @(posedge clk);
    #1;
    exp_data = model_load(3'd2, 8'h10);
    check("ar_post_ld", lsu_data, exp_data);
    check("ar_post_stall", 32'(stall), 32'(0));
    lsu_req = 1'b0;
    @(posedge clk);
    #1;

    // Randomized accesses against the byte-level model
    for (int n = 0; n < 300; n++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) :
           3'($urandom_range(0, 5));
      do_access("rnd", 1'($urandom), sz, 24'($urandom), 8'($urandom), $urandom,
                g_be, g_ld, g_flt);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu.md
Name: miriscv_lsu

Overview:
- Load-store unit between the core's execute stage and the data port of the on-chip RAM.
- Converts a core access into a word-aligned RAM request:
  - address alignment and byte-enable generation;
  - store-data lane replication;
  - load-data lane extraction with sign or zero extension.
- Stalls the core for exactly one cycle per access through a two-state FSM.
- Reports misaligned accesses and illegal sizes without touching memory.

Parameters:
- None. Size encoding is fixed: 3'd0 B, 3'd1 H, 3'd2 W, 3'd4 BU, 3'd5 HU. All other codes are illegal.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
lsu_req_i  in  1  core memory access request
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  access size/sign code
lsu_addr_i  in  32  byte address
lsu_data_i  in  32  store data, right-aligned
lsu_stall_req_o  out  1  core stall request
lsu_data_o  out  32  extended load result, registered
lsu_fault_o  out  1  misaligned/illegal-size flag, one-cycle pulse
data_req_o  out  1  RAM request
data_we_o  out  1  RAM write enable
data_be_o  out  4  RAM byte enables
data_addr_o  out  32  RAM word address {lsu_addr_i[31:2],2'b00}
data_wdata_o  out  32  RAM write data
data_rdata_i  in  32  RAM read data, combinational from data_addr_o

Behaviour:
- Clock is clk_i. Reset is rst_n_i, asynchronous, active-low.
- Reset forces state IDLE, lsu_data_o = 0, lsu_fault_o = 0. All combinational outputs evaluate from IDLE.
- Core holds all lsu_* inputs stable while lsu_stall_req_o = 1.
- FSM states: IDLE, DONE.
- IDLE, lsu_req_i = 0:
  - all data_* control outputs are 0; stall = 0.
- IDLE, lsu_req_i = 1:
  - stall = 1 (combinational); next state is DONE.
  - Legal, aligned access:
    - data_req_o = 1, data_we_o = lsu_we_i.
    - Load: at the clock edge, lsu_data_o <= extracted data_rdata_i.
    - Store: lsu_data_o holds its value.
    - lsu_fault_o <= 0.
  - Fault (H/HU with addr[0] = 1; W with addr[1:0] != 0; size code 3, 6 or 7):
    - data_req_o = 0, data_we_o = 0.
    - lsu_fault_o <= 1; lsu_data_o unchanged.
- DONE:
  - stall = 0, data_req_o = 0.
  - lsu_fault_o <= 0 at the next edge; next state is IDLE unconditionally.
  - A request present in DONE is ignored; it is accepted in the following IDLE cycle.
  - Every access costs exactly 2 cycles. There is no back-to-back acceptance.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
  - Faults: 4'b0000.
- Store data:
  - B: the byte replicated 4x.
  - H: the halfword replicated 2x.
  - W: passed through.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: passed through.
- data_addr_o always equals {lsu_addr_i[31:2],2'b00}. It is valid even when data_req_o = 0.
- Reset asserted in DONE or mid-IDLE:
  - immediately IDLE, stall and req drop to 0, registers cleared.
  - No RAM write occurs on that edge, because the RAM also samples reset.
- lsu_req_i dropping while in DONE has no effect.

Test Plan:
1. Word store/load: store 0xDEADBEEF at 0x10, then load W from 0x10.
   - Store: data_be_o = 4'hF, stall high for 1 cycle.
   - Load: lsu_data_o = 0xDEADBEEF in the DONE cycle.
2. Byte loads: mem[0x20] = 0x80FF7F01.
   - B @0x23 -> 0xFFFFFF80.
   - BU @0x23 -> 0x00000080.
   - B @0x21 -> 0x0000007F.
3. Halfword store then load:
   - SH 0x1234 @0x32 -> data_be_o = 4'b1100, data_wdata_o = 0x12341234; word at 0x30 has only bits [31:16] changed.
   - Load H @0x32 of 0x8001xxxx -> 0xFFFF8001.
   - Load HU @0x32 of 0x8001xxxx -> 0x00008001.
4. Faults:
   - W @0x12 and H @0x13 each give data_req_o = 0 and a one-cycle lsu_fault_o pulse; memory is unchanged.
   - Size code 3 gives the same response.
5. Back-to-back: lsu_req_i held high for 4 cycles with stable inputs.
   - Stall pattern 1,0,1,0.
   - data_req_o pattern 1,0,1,0.
6. Async reset: deassert rst_n_i mid-cycle while in DONE.
   - stall, data_req_o, lsu_data_o and lsu_fault_o go to 0 without waiting for a clock edge.
   - After release, the first request is accepted in IDLE.
